timer_dev: RTL
==============

TIMER_DEV -- requirements
Module: timer_dev

Interface
REQ-001 The block SHALL have no parameters; the register map and counter width are fixed at 32 bits.
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-004 The block SHALL have port addr, input, [3:2], the word select (0=CTRL, 1=PRESET, 2=COUNT, 3=reserved).
REQ-005 The block SHALL have port we, input, 1, the bus write strobe, sampled at the clk edge.
REQ-006 The block SHALL have port din, input, [31:0], the bus write data.
REQ-007 The block SHALL have port dout, output, [31:0], the combinational read data for addr.
REQ-008 The block SHALL have port irq, output, 1, the interrupt request that feeds one HWInt line of the CPU.

Function
REQ-009 CTRL SHALL use bit0 Enable, bits[2:1] Mode and bit3 IM (interrupt mask); bits[31:4] SHALL read as 0 and ignore writes.
REQ-010 PRESET SHALL be a read/write 32-bit register; COUNT SHALL be read-only, and writes to COUNT or to addr 3 SHALL be ignored.
REQ-011 A read of addr 3 SHALL return 0.
REQ-012 The FSM SHALL have four states: IDLE, LOAD, CNT and INT.
REQ-013 IDLE SHALL go to LOAD when Enable=1 and SHALL stay in IDLE otherwise.
REQ-014 LOAD SHALL set COUNT to PRESET and go to CNT.
REQ-015 In CNT with Enable=0, the FSM SHALL go to IDLE and COUNT SHALL hold its value.
REQ-016 In CNT with COUNT>1, the block SHALL set COUNT to COUNT-1.
REQ-017 In CNT with COUNT equal to 0 or 1, the block SHALL set COUNT to 0 and go to INT.
REQ-018 INT SHALL last exactly one cycle and SHALL set the sticky flag irq_pending.
REQ-019 In Mode 00, INT SHALL clear Enable and go to IDLE.
REQ-020 irq SHALL equal IM AND irq_pending, registered with no combinational path from din.
REQ-021 Any bus write to CTRL or to PRESET SHALL clear irq_pending.
REQ-022 If the set and the clear of irq_pending occur in the same cycle, the set SHALL win.
REQ-023 If a bus write to CTRL and the hardware clear of Enable in INT occur in the same cycle, the bus value SHALL win.
REQ-024 A write to PRESET during CNT SHALL NOT change the running COUNT; the new value SHALL take effect at the next LOAD.
REQ-025 With PRESET=N≥1, if the CTRL write enabling the timer occurs at edge t0, irq (with IM=1) SHALL rise after edge t0+N+3; PRESET=0 SHALL behave as PRESET=1.
REQ-026 Counting SHALL NOT wrap: COUNT SHALL never decrement below 0.

Reset
REQ-027 When reset=1 at a clk edge, CTRL, PRESET, COUNT and irq_pending SHALL be set to 0, the FSM SHALL enter IDLE, and irq and dout(CTRL) SHALL read 0.
REQ-028 Reset SHALL override a bus write in the same cycle.
REQ-029 Reset asserted mid-count SHALL abort the count with no irq.

Configuration
REQ-030 With TIMER_AUTO_RELOAD_EN defined, Mode 01 SHALL make INT keep Enable and go to LOAD, giving a periodic irq_pending set every PRESET+2 cycles (PRESET≥1), and Modes 10 and 11 SHALL behave as 00.
REQ-031 Without TIMER_AUTO_RELOAD_EN, Mode bits SHALL ignore writes and read as 00, so every count SHALL be one-shot.

Verification
REQ-032 Reset test: reset held for 10 cycles, then a read of all addresses -> dout=0 and irq=0.
REQ-033 One-shot test: PRESET=5, then CTRL=0x9 at edge t0 -> COUNT reads 5,4,3,2,1,0, irq rises after edge t0+8, and CTRL then reads 0x8.
REQ-034 Mask and clear test: one-shot with IM=0 -> irq stays 0; a later write of CTRL=0x8 -> irq stays 0 and irq_pending is cleared; a re-run with IM=1 followed by a write to PRESET -> irq falls on the next edge.
REQ-035 Abort test: PRESET=100, enable, then CTRL=0x8 after 10 cycles -> COUNT freezes at 92, the FSM returns to IDLE, and no irq occurs.
REQ-036 Auto-reload test (macro defined): PRESET=3, CTRL=0xB -> irq_pending is set every 5 cycles, and COUNT reloads 3 after each INT.
REQ-037 Collision test: a CTRL write in the same cycle as INT -> irq_pending=1 and CTRL equals the written value.

Source files
------------

// File: rtl/timer_dev.sv
// Bus-mapped 32-bit down-counting timer with one-shot interrupt (IDLE/LOAD/CNT/INT).
// Define TIMER_AUTO_RELOAD_EN to enable Mode 01 periodic reload.
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:2]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;
  logic        wr_ctrl, wr_pre, reload;

  assign wr_ctrl = we && (addr == 2'd0);
  assign wr_pre  = we && (addr == 2'd1);

`ifdef TIMER_AUTO_RELOAD_EN
  assign reload = (mode_q == 2'b01);
`else
  assign reload = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;
    unique case (state_q)
      IDLE: if (en_q) state_d = LOAD;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en_q) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'd0;
          state_d = INT;
        end
      end
      INT: begin
        if (reload) begin
          state_d = LOAD;
        end else begin
          en_d    = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
    // Bus writes come after the FSM so they win over the INT enable clear
    if (wr_ctrl) begin
      en_d = din[0];
      im_d = din[3];
`ifdef TIMER_AUTO_RELOAD_EN
      mode_d = din[2:1];
`else
      mode_d = 2'b00;
`endif
    end
    if (wr_pre) preset_d = din;
    if (wr_ctrl || wr_pre) pend_d = 1'b0;
    if (state_q == INT) pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'b00;
      im_q     <= 1'b0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    dout = 32'd0;
    case (addr)
      2'd0:    dout = {28'd0, im_q, mode_q, en_q};
      2'd1:    dout = preset_q;
      2'd2:    dout = count_q;
      default: dout = 32'd0;
    endcase
  end

  assign irq = im_q & pend_q;

endmodule
